// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Lets NREQ byte-stream requesters share one uart TX path. Whole packets are
//   granted round-robin and never interleaved. Each requester has its own frame
//   config. A new config is applied only once the uart is fully idle, so no
//   frame is ever sent with mixed settings.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/last    per-requester byte valid / last-of-packet
//   i_req_data          requester k byte at [k*DBITS +: DBITS]
//   i_req_cfg           requester k {par[1:0],d_num,s_num,bd_rate[1:0]} at [k*6 +: 6]
//   o_req_ready         byte accepted on valid & ready
//   o_grant             one-hot current owner, 0 when none
//   o_busy              FSM not idle
//   i_tx_full/i_tx_idle uart FIFO full / FIFO empty and transmitter idle
//   o_wr_uart/o_wr_data uart TX FIFO write strobe and byte
//   o_par..o_bd_rate    applied frame config
module uart_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int DBITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ-1:0]       i_req_last,
  input  logic [NREQ*DBITS-1:0] i_req_data,
  input  logic [NREQ*6-1:0]     i_req_cfg,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy,
  input  logic                  i_tx_full,
  input  logic                  i_tx_idle,
  output logic                  o_wr_uart,
  output logic [DBITS-1:0]      o_wr_data,
  output logic [1:0]            o_par,
  output logic                  o_d_num,
  output logic                  o_s_num,
  output logic [1:0]            o_bd_rate
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // par=none, 8 data bits, 1 stop bit, 1200 baud
  localparam logic [5:0] CFG_RST = 6'b00_1_0_00;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_DRAIN, S_APPLY, S_SEND} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;     // last owner; search starts just above it
  logic [PW-1:0]   gidx_q, gidx_d;   // current owner index
  logic [5:0]      cfg_q, cfg_d;     // owner's config snapshot taken in ARB
  logic [5:0]      app_q, app_d;     // config currently driven to the uart

  logic [DBITS-1:0] data_arr [NREQ];
  logic [5:0]       cfg_arr  [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign data_arr[k] = i_req_data[k*DBITS +: DBITS];
    assign cfg_arr[k]  = i_req_cfg[k*6 +: 6];
  end

  // Round-robin pick: first valid index above ptr_q, wrapping.
  logic [PW-1:0] arb_idx;
  logic          arb_hit;
  always_comb begin
    int c;
    logic [PW-1:0] ci;
    arb_idx = '0;
    arb_hit = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NREQ) c = c - NREQ;
      ci = PW'(c);
      if (!arb_hit && i_req_valid[ci]) begin
        arb_hit = 1'b1;
        arb_idx = ci;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    cfg_d       = cfg_q;
    app_d       = app_q;
    o_req_ready = '0;
    o_grant     = '0;
    o_wr_uart   = 1'b0;
    o_wr_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (|i_req_valid) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_hit) begin
          gidx_d  = arb_idx;
          cfg_d   = cfg_arr[arb_idx];
          state_d = (cfg_arr[arb_idx] == app_q) ? S_SEND : S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        o_grant[gidx_q] = 1'b1;
        if (i_tx_idle) state_d = S_APPLY;
      end
      S_APPLY: begin
        o_grant[gidx_q] = 1'b1;
        app_d           = cfg_q;
        state_d         = S_SEND;
      end
      S_SEND: begin
        // Grant stays locked until the last byte, even if valid drops.
        o_grant[gidx_q]     = 1'b1;
        o_req_ready[gidx_q] = ~i_tx_full;
        o_wr_uart           = i_req_valid[gidx_q] & ~i_tx_full;
        o_wr_data           = data_arr[gidx_q];
        if (o_wr_uart && i_req_last[gidx_q]) begin
          ptr_d   = gidx_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gidx_q  <= '0;
      cfg_q   <= '0;
      app_q   <= CFG_RST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cfg_q   <= cfg_d;
      app_q   <= app_d;
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_par     = app_q[5:4];
  assign o_d_num   = app_q[3];
  assign o_s_num   = app_q[2];
  assign o_bd_rate = app_q[1:0];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int DBITS = 8;
  localparam logic [5:0] DEF  = 6'b00_1_0_00;
  localparam logic [5:0] CFG1 = 6'b01_1_1_01;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic [NREQ-1:0]       i_req_valid, i_req_last, o_req_ready, o_grant;
  logic [NREQ*DBITS-1:0] i_req_data;
  logic [NREQ*6-1:0]     i_req_cfg;
  logic                  o_busy, i_tx_full, i_tx_idle, o_wr_uart, o_d_num, o_s_num;
  logic [DBITS-1:0]      o_wr_data;
  logic [1:0]            o_par, o_bd_rate;

  uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_last(i_req_last),
    .i_req_data(i_req_data), .i_req_cfg(i_req_cfg), .o_req_ready(o_req_ready),
    .o_grant(o_grant), .o_busy(o_busy), .i_tx_full(i_tx_full), .i_tx_idle(i_tx_idle),
    .o_wr_uart(o_wr_uart), .o_wr_data(o_wr_data), .o_par(o_par), .o_d_num(o_d_num),
    .o_s_num(o_s_num), .o_bd_rate(o_bd_rate));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic [5:0] cfg; } rbyte_t;
  typedef struct { int req; logic [7:0] data; logic [5:0] cfg; } exp_t;
  typedef struct { int grp; int req; int nb; logic [5:0] cfg; logic [7:0] base; } vec_t;

  rbyte_t rq [NREQ][$];
  exp_t   sb [$];
  vec_t   tbl [16];

  int checks = 0, errors = 0, wr_cnt = 0;
  logic rst_v = 1'b1, full_v = 1'b0, idle_v = 1'b1;
  logic [NREQ-1:0] hold_v = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] out_cfg();
    return {o_par, o_d_num, o_s_num, o_bd_rate};
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, pop accepted bytes.
  task automatic cycle();
    logic [NREQ-1:0] acc;
    exp_t e;
    @(negedge clk);
    i_rst = rst_v; i_tx_full = full_v; i_tx_idle = idle_v;
    for (int k = 0; k < NREQ; k++) begin
      if (rq[k].size() > 0 && !hold_v[k]) begin
        i_req_valid[k] = 1'b1;
        i_req_last[k]  = rq[k][0].last;
        i_req_data[k*DBITS +: DBITS] = rq[k][0].data;
        i_req_cfg[k*6 +: 6] = rq[k][0].cfg;
      end else begin
        i_req_valid[k] = 1'b0;
        i_req_last[k]  = 1'b0;
      end
    end
    #1;
    acc = i_req_valid & o_req_ready;
    if (o_wr_uart !== |acc) chk("wr_vs_handshake", {31'd0, o_wr_uart}, {31'd0, |acc});
    if (o_wr_uart) begin
      wr_cnt++;
      if (sb.size() == 0) chk("unexpected_wr", {24'd0, o_wr_data}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("wr_data", {24'd0, o_wr_data}, {24'd0, e.data});
        chk("wr_grant", {28'd0, o_grant}, 32'd1 << e.req);
        chk("wr_cfg", {26'd0, out_cfg()}, {26'd0, e.cfg});
      end
    end
    for (int k = 0; k < NREQ; k++) if (acc[k]) void'(rq[k].pop_front());
  endtask

  task automatic do_reset(input string nm);
    for (int k = 0; k < NREQ; k++) rq[k].delete();
    sb.delete();
    hold_v = '0; full_v = 1'b0; idle_v = 1'b1;
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk({nm, "_grant"}, {28'd0, o_grant}, 32'd0);
    chk({nm, "_wr"},    {31'd0, o_wr_uart}, 32'd0);
    chk({nm, "_ready"}, {28'd0, o_req_ready}, 32'd0);
    chk({nm, "_busy"},  {31'd0, o_busy}, 32'd0);
    chk({nm, "_data"},  {24'd0, o_wr_data}, 32'd0);
    chk({nm, "_cfg"},   {26'd0, out_cfg()}, {26'd0, DEF});
  endtask

  task automatic load_grp(input int g);
    rbyte_t r;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].grp == g) begin
        for (int b = 0; b < tbl[i].nb; b++) begin
          r.data = tbl[i].base + 8'(b);
          r.last = (b == tbl[i].nb - 1);
          r.cfg  = tbl[i].cfg;
          rq[tbl[i].req].push_back(r);
          e.req = tbl[i].req; e.data = r.data; e.cfg = tbl[i].cfg;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_wr(input string nm, input int n, input int budget, output int used);
    int target;
    target = wr_cnt + n;
    used = 0;
    while (wr_cnt < target && used < budget) begin
      cycle();
      used++;
    end
    if (wr_cnt < target) chk({nm, "_wr_timeout"}, wr_cnt, target);
  endtask

  task automatic drain_all(input string nm, input int budget);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      cycle();
      n++;
      pend = (sb.size() != 0);
      for (int k = 0; k < NREQ; k++) if (rq[k].size() != 0) pend = 1'b1;
    end
    chk({nm, "_sb_empty"}, sb.size(), 0);
    cycle();
    chk({nm, "_idle_busy"},  {31'd0, o_busy}, 32'd0);
    chk({nm, "_idle_grant"}, {28'd0, o_grant}, 32'd0);
  endtask

  initial begin
    int used;
    // grp, req, bytes, cfg, first byte; table order within a group = expected grant order
    tbl[0]  = '{1, 0, 3, DEF,  8'h10};
    tbl[1]  = '{1, 2, 3, DEF,  8'h20};
    tbl[2]  = '{2, 1, 2, CFG1, 8'h30};
    tbl[3]  = '{3, 0, 6, DEF,  8'h40};
    tbl[4]  = '{4, 0, 1, DEF,  8'h50};
    tbl[5]  = '{4, 1, 1, DEF,  8'h51};
    tbl[6]  = '{4, 2, 1, DEF,  8'h52};
    tbl[7]  = '{4, 3, 1, DEF,  8'h53};
    tbl[8]  = '{4, 0, 1, DEF,  8'h54};
    tbl[9]  = '{4, 1, 1, DEF,  8'h55};
    tbl[10] = '{4, 2, 1, DEF,  8'h56};
    tbl[11] = '{4, 3, 1, DEF,  8'h57};
    tbl[12] = '{5, 0, 5, DEF,  8'h60};
    tbl[13] = '{5, 1, 1, DEF,  8'h70};
    tbl[14] = '{5, 2, 1, DEF,  8'h71};
    tbl[15] = '{6, 1, 4, CFG1, 8'h80};

    i_rst = 1'b1; i_req_valid = '0; i_req_last = '0; i_req_data = '0;
    i_req_cfg = {NREQ{DEF}}; i_tx_full = 1'b0; i_tx_idle = 1'b1;

    // two same-config packets: req0 then req2, no drain (SEND on 3rd cycle)
    do_reset("rst0");
    load_grp(1);
    wait_wr("t1", 1, 20, used);
    chk("t1_first_wr_latency", used, 3);
    drain_all("t1", 100);

    // config change waits for uart idle, applied only before first byte
    do_reset("rst2");
    load_grp(2);
    idle_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_no_wr_drain", {31'd0, o_wr_uart}, 32'd0);
      chk("t2_cfg_held", {26'd0, out_cfg()}, {26'd0, DEF});
    end
    chk("t2_grant_in_drain", {28'd0, o_grant}, 32'b0010);
    idle_v = 1'b1;
    drain_all("t2", 50);
    chk("t2_cfg_applied", {26'd0, out_cfg()}, {26'd0, CFG1});

    // uart full for 5 cycles mid-packet
    do_reset("rst3");
    load_grp(3);
    wait_wr("t3", 2, 50, used);
    full_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_no_wr_full", {31'd0, o_wr_uart}, 32'd0);
      chk("t3_no_ready_full", {28'd0, o_req_ready}, 32'd0);
    end
    full_v = 1'b0;
    cycle();
    chk("t3_resume_wr", {31'd0, o_wr_uart}, 32'd1);
    drain_all("t3", 50);

    // all requesters busy with 1-byte packets: strict rotation 0,1,2,3,0,...
    do_reset("rst4");
    load_grp(4);
    drain_all("t4", 100);

    // owner drops valid mid-packet while others wait: grant stays locked
    do_reset("rst5");
    load_grp(5);
    wait_wr("t5", 2, 50, used);
    hold_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_grant_locked", {28'd0, o_grant}, 32'b0001);
      chk("t5_no_wr_gap", {31'd0, o_wr_uart}, 32'd0);
    end
    hold_v[0] = 1'b0;
    drain_all("t5", 100);

    // reset mid-packet after a non-default config was applied
    do_reset("rst6a");
    load_grp(6);
    wait_wr("t6", 2, 50, used);
    chk("t6_cfg_before_rst", {26'd0, out_cfg()}, {26'd0, CFG1});
    do_reset("t6_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
